// File: rtl/ct_op_feeder_if.sv
// Element-in / operand-pair-out bundle for ct_op_feeder; master drives elements and op_ready.
// op_tag exists only when CT_FEED_FRAME_TAG_EN is defined.
interface ct_op_feeder_if #(
  parameter int DWT   = 8,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DWT-1:0]       in_data;
  logic                 in_last;
  logic                 op_valid;
  logic                 op_ready;
  logic [2*DWT-1:0]     op_out;
  logic                 op_first;
  logic                 op_last;
`ifdef CT_FEED_FRAME_TAG_EN
  logic [TAG_W-1:0]     op_tag;

  modport master (output in_valid, in_data, in_last, op_ready,
                  input  in_ready, op_valid, op_out, op_first, op_last, op_tag);
  modport slave  (input  in_valid, in_data, in_last, op_ready,
                  output in_ready, op_valid, op_out, op_first, op_last, op_tag);
`else
  modport master (output in_valid, in_data, in_last, op_ready,
                  input  in_ready, op_valid, op_out, op_first, op_last);
  modport slave  (input  in_valid, in_data, in_last, op_ready,
                  output in_ready, op_valid, op_out, op_first, op_last);
`endif

  if (TAG_W < 1) begin : g_bad_tag_w
    $error("ct_op_feeder_if: TAG_W must be at least 1");
  end
endinterface

// File: rtl/ct_op_feeder.sv
// Ping-pong frame buffer feeding operand pairs {elem[2k+1],elem[2k]} to the argmax tree; optional CT_FEED_FRAME_TAG_EN adds op_tag.
// Latency: first pair the cycle after the closing element; one bubble cycle between back-to-back frames.
// Backpressure: in_ready drops while the write bank is full; op_valid/op_out hold steady while op_ready is low.
module ct_op_feeder #(
  parameter int DWT    = 8,
  parameter int FRAC   = 4,
  parameter int N_PAIR = 4,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  ct_op_feeder_if.slave bus
);
  localparam int NE = 2 * N_PAIR;
  localparam int IW = $clog2(NE);
  localparam int PW = (N_PAIR > 1) ? $clog2(N_PAIR) : 1;
  localparam int CW = $clog2(NE + 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t         state, state_nxt;
  logic [DWT-1:0] mem [2][NE];
  logic [1:0]     full;
  logic [CW-1:0]  cnt [2];
  logic           wr_bank, rd_bank, rdy_en;
  logic [IW-1:0]  wr_idx;
  logic [PW-1:0]  rd_pair;
  logic           wr_fire, wr_close, rd_fire, rd_done, pair_last;
  logic [IW-1:0]  ev_idx, od_idx;
  logic [DWT-1:0] ev_dat, od_dat;

  if (N_PAIR < 1 || N_PAIR > 64) begin : g_bad_npair
    $error("ct_op_feeder: N_PAIR must be within 1..64");
  end
  if (FRAC < 0 || FRAC > DWT || TAG_W < 1) begin : g_bad_fmt
    $error("ct_op_feeder: FRAC must be within 0..DWT and TAG_W at least 1");
  end

  // rdy_en keeps in_ready low until the first cycle after reset is released
  assign bus.in_ready = rdy_en & ~full[wr_bank];
  assign wr_fire      = bus.in_valid & bus.in_ready;
  assign wr_close     = wr_fire & (bus.in_last | (wr_idx == IW'(NE - 1)));
  assign pair_last    = (rd_pair == PW'(N_PAIR - 1));
  assign rd_fire      = (state == S_STREAM) & bus.op_ready;
  assign rd_done      = rd_fire & pair_last;

  // Elements past the frame's valid count read as zero so padding never wins
  assign ev_idx = IW'({rd_pair, 1'b0});
  assign od_idx = ev_idx | IW'(1);
  assign ev_dat = (CW'(ev_idx) < cnt[rd_bank]) ? mem[rd_bank][ev_idx] : '0;
  assign od_dat = (CW'(od_idx) < cnt[rd_bank]) ? mem[rd_bank][od_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      full    <= '0;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_pair <= '0;
      rdy_en  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
        rd_pair       <= '0;
      end else if (rd_fire) begin
        rd_pair <= rd_pair + PW'(1);
      end
      if (wr_fire) begin
        if (wr_close) begin
          full[wr_bank] <= 1'b1;
          cnt[wr_bank]  <= CW'(wr_idx) + CW'(1);
          wr_idx        <= '0;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_idx] <= bus.in_data;
  end

  always_comb begin
    state_nxt    = state;
    bus.op_valid = 1'b0;
    bus.op_out   = '0;
    bus.op_first = 1'b0;
    bus.op_last  = 1'b0;
    case (state)
      S_IDLE: begin
        // A frame closing into the read bank starts streaming without a wait cycle
        if (full[rd_bank] | (wr_close & (wr_bank == rd_bank))) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        bus.op_valid = 1'b1;
        bus.op_out   = {od_dat, ev_dat};
        bus.op_first = (rd_pair == '0);
        bus.op_last  = pair_last;
        if (bus.op_ready && pair_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef CT_FEED_FRAME_TAG_EN
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] bank_tag [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_cnt     <= '0;
      bank_tag[0] <= '0;
      bank_tag[1] <= '0;
    end else if (wr_close) begin
      bank_tag[wr_bank] <= tag_cnt;
      tag_cnt           <= tag_cnt + TAG_W'(1);
    end
  end

  assign bus.op_tag = (state == S_STREAM) ? bank_tag[rd_bank] : '0;
`endif
endmodule

// File: tb/tb_ct_op_feeder.sv
// Directed bench for ct_op_feeder: full/short frames, backpressure, back-to-back release, mid-stream reset.
// Tag sequence is exercised when CT_FEED_FRAME_TAG_EN is defined.
module tb_ct_op_feeder;
  localparam int DWT    = 8;
  localparam int N_PAIR = 4;
  localparam int TAG_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ct_op_feeder_if #(.DWT(DWT), .TAG_W(TAG_W)) bus ();

  ct_op_feeder #(.DWT(DWT), .FRAC(4), .N_PAIR(N_PAIR), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0]      pq[$];
  logic             fq[$];
  logic             lq[$];
  int               cq[$];
  logic [TAG_W-1:0] tq[$];

  // Record every accepted pair with the cycle it was presented in
  always @(negedge clk) begin
    if (!rst && bus.op_valid && bus.op_ready) begin
      pq.push_back(bus.op_out);
      fq.push_back(bus.op_first);
      lq.push_back(bus.op_last);
      cq.push_back(cyc);
`ifdef CT_FEED_FRAME_TAG_EN
      tq.push_back(bus.op_tag);
`else
      tq.push_back('0);
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    pq.delete(); fq.delete(); lq.delete(); cq.delete(); tq.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int hcyc);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    hcyc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_pairs(input int n);
    int t = 0;
    while (pq.size() < n && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("pair_count", pq.size(), n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "tb_ct_op_feeder watchdog");
  end

  initial begin
    int h;
    int r;
    int t;
    logic [15:0] exp1 [4];
    exp1 = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.op_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_op_out", bus.op_out, 0);
    check("rst_first_last", {bus.op_first, bus.op_last}, 0);
`ifdef CT_FEED_FRAME_TAG_EN
    check("rst_op_tag", bus.op_tag, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Full frame, back-to-back, op_ready high
    bus.op_ready = 1'b1;
    clear_q();
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, h);
    wait_pairs(4);
    for (int i = 0; i < 4; i++) check($sformatf("full_pair%0d", i), pq[i], exp1[i]);
    check("full_first", {fq[0], fq[1], fq[2], fq[3]}, 4'b1000);
    check("full_last", {lq[0], lq[1], lq[2], lq[3]}, 4'b0001);
    check("full_latency", cq[0], h + 1);
    check("full_contig", cq[3], h + 4);

    // Short frame zero-padded
    clear_q();
    send(8'hA0, 1'b0, h);
    send(8'hB0, 1'b0, h);
    send(8'hC0, 1'b1, h);
    wait_pairs(4);
    check("short_p0", pq[0], 16'hB0A0);
    check("short_p1", pq[1], 16'h00C0);
    check("short_p2", pq[2], 16'h0000);
    check("short_p3", pq[3], 16'h0000);
    check("short_last", lq[3], 1);

    // Backpressure: two frames buffered, third offered
    bus.op_ready = 1'b0;
    clear_q();
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, h);
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b0, h);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h30;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_hold_out", bus.op_out, 16'h1110);
      check("bp_hold_valid", bus.op_valid, 1);
    end
    @(posedge clk); #1;
    bus.op_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    r = cyc;
    check("bp_ready_return", r, (cq.size() >= 4) ? cq[3] + 1 : -1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    send(8'h31, 1'b1, h);
    wait_pairs(12);
    check("bp_f0_p3", pq[3], 16'h1716);
    check("bp_f1_p0", pq[4], 16'h2120);
    check("bp_f1_p3", pq[7], 16'h2726);
    check("bp_f2_p0", pq[8], 16'h3130);
    check("bp_f2_p1", pq[9], 16'h0000);

    // Frame B closes in the cycle frame A's last pair is accepted
    clear_q();
    for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), 1'b0, h);
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), (i == 3), r);
    wait_pairs(8);
    check("sim_close_cycle", r, cq[3]);
    check("sim_a_last", pq[3], 16'h5756);
    check("sim_b_p0", pq[4], 16'h4241);
    check("sim_b_p1", pq[5], 16'h4443);
    check("sim_b_p2", pq[6], 16'h0000);
    check("sim_bubble", cq[4], cq[3] + 2);

    // Reset after pair 2 of a frame
    bus.op_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 1'b0, h);
    clear_q();
    bus.op_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_op_valid", bus.op_valid, 0);
    check("mrst_op_out", bus.op_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_pairs_before", pq.size(), 2);
    check("mrst_pair1", pq[1], 16'h6362);
    clear_q();
    for (int i = 0; i < 8; i++) send(8'h01 + 8'(i), 1'b0, h);
    wait_pairs(4);
    check("mrst_new_p0", pq[0], 16'h0201);
    check("mrst_new_p3", pq[3], 16'h0807);
    repeat (10) @(negedge clk);
    check("mrst_no_extra", pq.size(), 4);

`ifdef CT_FEED_FRAME_TAG_EN
    // Tag sequence across five frames wraps at 2^TAG_W
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    for (int f = 0; f < 5; f++) begin
      send(8'(f * 16 + 1), 1'b0, h);
      send(8'(f * 16 + 2), 1'b1, h);
    end
    wait_pairs(20);
    check("tag_f0", tq[0], 0);
    check("tag_f1", tq[4], 1);
    check("tag_f2", tq[8], 2);
    check("tag_f3", tq[12], 3);
    check("tag_f4", tq[16], 0);
    check("tag_stable", tq[7], 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ct_op_feeder.md
Name: ct_op_feeder

Overview:
- Upstream feeder for the comparison-tree (argmax) stage.
- Accepts a serial stream of unsigned fixed-point scores, one per handshake, and collects each frame of 2*N_PAIR elements into a ping-pong frame buffer.
- Replays each full frame as N_PAIR consecutive operand pairs on a packed 2*DWT bus, in the layout the tree's first comparison layer expects.
- Double buffering lets frame n+1 load while frame n is being streamed out.

Parameters:
- DWT, 8, element width in bits (unsigned, Q(DWT-FRAC).FRAC).
- FRAC, 4, fractional bits; informational only, no arithmetic depends on it.
- N_PAIR, 4, operand pairs per frame; frame length is 2*N_PAIR elements; legal values are 1..64.
- TAG_W, 4, frame tag width; used only when CT_FEED_FRAME_TAG_EN is defined.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, input element valid.
- in_ready, out, 1, feeder can accept an element.
- in_data, in, DWT, input element.
- in_last, in, 1, marks the final element of a short frame.
- op_valid, out, 1, operand pair valid.
- op_ready, in, 1, downstream accepts the pair.
- op_out, out, 2*DWT, {elem[2k+1], elem[2k]}; the low half is the even index.
- op_first, out, 1, high with pair k=0.
- op_last, out, 1, high with pair k=N_PAIR-1.
- op_tag, out, TAG_W, frame sequence number; present only when CT_FEED_FRAME_TAG_EN is defined.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high. It is sampled on the rising edge of clk while rst=1.
  - Reset clears both banks to empty, sets wr_bank=0, rd_bank=0, wr_idx=0, rd_pair=0 and clears the read FSM to IDLE.
  - Output reset values: in_ready=0 during reset and 1 the cycle after reset deasserts. op_valid=0, op_out=0, op_first=0, op_last=0, op_tag=0.
  - A reset asserted mid-frame discards all buffered data. No partial pair is emitted afterwards.
- Storage:
  - Two banks of 2*N_PAIR x DWT registers.
  - Per-bank state: full flag and cnt, which holds the number of valid elements (1..2*N_PAIR).
- Write side:
  - in_ready = !full[wr_bank]. This is combinational from registered state only.
  - On in_valid & in_ready: bank[wr_bank][wr_idx] <= in_data.
  - If wr_idx == 2*N_PAIR-1 or in_last is high, the frame closes:
    - full[wr_bank] <= 1, cnt <= wr_idx+1, wr_idx <= 0, wr_bank toggles.
    - When the frame closes at wr_idx == 2*N_PAIR-1, in_last is ignored.
  - Otherwise wr_idx increments.
  - A frame is never spread across banks.
- Read FSM:
  - IDLE: op_valid=0. When full[rd_bank]=1, go to STREAM with rd_pair=0. The earliest first pair appears the cycle after the closing input handshake, so latency is 1 cycle.
  - STREAM: op_valid=1. op_out carries pair rd_pair of bank rd_bank.
    - Any element index >= cnt reads as 0, the minimum unsigned value, so padding never wins a comparison.
    - op_first = (rd_pair==0), op_last = (rd_pair==N_PAIR-1).
  - On op_valid & op_ready in STREAM:
    - Not the last pair: rd_pair increments.
    - Last pair: full[rd_bank] <= 0, rd_bank toggles, rd_pair <= 0.
    - After the last pair, the FSM returns to IDLE. It goes back to STREAM on the next cycle if the other bank is full, which gives 1 bubble cycle between frames.
  - op_valid and op_out stay stable while op_ready=0; the AXI-style no-retract rule applies.
- Simultaneous events:
  - The write side may close a frame into bank A in the same cycle the read side releases bank B. Both updates take effect.
  - When a write closes a frame into the bank the read side is releasing, the release happens first, and in_ready was already 0 in that cycle, so no conflict occurs.
- Both banks full: in_ready=0 until the read side releases a bank. The released bank is writable the next cycle.
- Empty: op_valid=0 and op_out holds 0.
- Counter widths: wr_idx is clog2(2*N_PAIR) bits and rd_pair is clog2(N_PAIR) bits, minimum 1 bit each. Neither counter ever wraps past its frame bound.

Optional Feature:
- Macro: CT_FEED_FRAME_TAG_EN.
- Defined:
  - A TAG_W-bit frame counter increments on each frame close and wraps modulo 2^TAG_W.
  - Each bank stores the tag of the frame it holds.
  - op_tag outputs the tag of the frame being streamed and is stable for all pairs of that frame.
  - Reset sets the counter to 0, so the first frame carries tag 0.
- Undefined: the port op_tag, the counter and the per-bank tag storage do not exist.

Test Plan:
- Reset, then N_PAIR=4 with elements 0x10..0x17 streamed back-to-back and op_ready=1 -> four pairs 0x1110, 0x1312, 0x1514, 0x1716. op_first is high on the first pair and op_last on the fourth. The first op_valid occurs 1 cycle after the 8th handshake.
- Short frame: 3 elements 0xA0, 0xB0, 0xC0 with in_last on the 3rd -> pairs 0xB0A0, 0x00C0, 0x0000, 0x0000.
- Backpressure: op_ready=0 while 2 frames are input, then a 3rd frame is offered -> in_ready drops after the 16th handshake. op_out holds 0x1110 unchanged. Once op_ready rises, in_ready returns 1 cycle after the 4th pair of frame 0 is accepted.
- Simultaneous: close frame 1 in the same cycle frame 0's last pair is accepted -> both complete. Frame 1's first pair appears after exactly 1 bubble cycle.
- Reset mid-stream, asserted after pair 2 of a frame -> op_valid=0 the next cycle. A new frame 0x01..0x08 then yields 0x0201 as its first pair, with no stale data.
- CT_FEED_FRAME_TAG_EN with TAG_W=2: 5 frames -> op_tag sequence 0, 1, 2, 3, 0.
